// File: rtl/mem_sram_initiator.sv
// Valid/ready request adapter onto a 1-cycle-latency byte-strobed SRAM port, with a 2-entry response buffer.
// Optional misaligned-address rejection: define MEM_SRAM_INIT_ALIGN_CHECK_EN.
module mem_sram_initiator #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 11
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wen,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WIDTH/8-1:0]   req_strb,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 rsp_error,
  output logic                 mem_cen,
  output logic [WIDTH/8-1:0]   mem_wstrb,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [WIDTH-1:0]     mem_rdata
);
  localparam int SW = WIDTH / 8;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] rdata;
  } rsp_t;

  logic [1:0] count;
  logic       inflight, inf_wen, inf_err;
  logic       wr_ptr, rd_ptr;
  rsp_t       fifo [2];

  logic accept, req_err, bypass, push, pop;
  rsp_t inf_rsp, rsp_sel;

`ifdef MEM_SRAM_INIT_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(SW - 1);
  assign req_err = |(req_addr & ALIGN_MASK);
`else
  assign req_err = 1'b0;
`endif

  // Credit rule: outstanding responses (buffered + in flight) never exceed FIFO depth.
  assign req_ready = !g_reset && (({1'b0, count} + {2'b00, inflight}) < 3'd2);
  assign accept    = req_valid && req_ready;

  assign mem_cen   = accept && !req_err;
  assign mem_wstrb = (mem_cen && req_wen) ? req_strb : '0;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  assign inf_rsp.err   = inf_err;
  assign inf_rsp.rdata = (inf_wen || inf_err) ? '0 : mem_rdata;

  assign rsp_valid = (count != 2'd0) || inflight;
  assign rsp_sel   = (count != 2'd0) ? fifo[rd_ptr] : inf_rsp;
  assign rsp_rdata = rsp_valid ? rsp_sel.rdata : '0;
  assign rsp_error = rsp_valid && rsp_sel.err;

  // SRAM data is only valid for one cycle, so anything not taken via bypass is captured.
  assign bypass = inflight && (count == 2'd0) && rsp_ready;
  assign push   = inflight && !bypass;
  assign pop    = (count != 2'd0) && rsp_ready;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      inflight <= 1'b0;
      inf_wen  <= 1'b0;
      inf_err  <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      assert (!(push && count == 2'd2));
      inflight <= accept;
      if (accept) begin
        inf_wen <= req_wen;
        inf_err <= req_err;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (push) fifo[wr_ptr] <= inf_rsp;
  end
endmodule

// File: doc/mem_sram_initiator.md
# mem_sram_initiator

Initiator-side adapter that drives the single-port, byte-strobed synchronous SRAM memory port (cen / wstrb / addr / wdata / 1-cycle rdata) from a valid/ready request channel. Returns one in-order response per accepted request on a valid/ready response channel, and buffers responses so the response consumer can stall without losing SRAM read data. It sits between a core or bus fabric port and a memory instance of the same WIDTH.

## Interface
- WIDTH, 64: data word width in bits; multiple of 8; equals memory WIDTH.
- ADDR_W, 11: byte address width; equals memory address width.
- g_clk  in  1  clock; all state on posedge.
- g_reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_strb  in  WIDTH/8  per-byte write enables; ignored for reads.
- req_wdata  in  WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  WIDTH  read data; 0 for writes and errors.
- rsp_error  out  1  request rejected (misaligned; see Configuration).
- mem_cen  out  1  memory enable.
- mem_wstrb  out  WIDTH/8  memory byte strobes.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data, valid the cycle after mem_cen.

## Operation
- State: inflight flag (+ wen, err tags) for the request issued last cycle; 2-entry response FIFO {rdata, error}; count 0..2.
- req_ready = !g_reset && (count + inflight) < 2. No combinational path from rsp_ready to req_ready.
- On accept: mem_cen = 1 (combinational, same cycle) unless request is an error; mem_addr = req_addr, mem_wdata = req_wdata, mem_wstrb = req_wen ? req_strb : 0. Otherwise mem_cen = 0, mem_wstrb = 0.
- Accept sets inflight next cycle with tags wen/err; no accept clears it.
- Response source: FIFO head if count > 0; else inflight bypass (rdata = mem_rdata, or 0 if wen|err). rsp_valid = count > 0 || inflight.
- Inflight response not consumed via bypass (rsp_ready low, or FIFO non-empty) is pushed into FIFO. Push and pop in the same cycle leave count unchanged.
- Writes with req_strb = 0 still issue mem_cen and return a normal response.
- Responses strictly in request order; exactly one response per accepted request.
- FIFO overflow impossible by the credit rule; pushing when count = 2 is a design error (assertion).

## Timing
- Read latency: accept in cycle N -> rsp_valid in cycle N+1 when response path empty.
- Throughput: one request per cycle sustained while rsp_ready = 1.
- rsp_ready low: at most 2 further responses held; req_ready drops once count + inflight = 2.
- Reset (async, any time): inflight, count, FIFO pointers clear; rsp_valid = 0, rsp_error = 0, rsp_rdata = 0, req_ready = 0, mem_cen = 0, mem_wstrb = 0 while asserted; req_ready = 1 first cycle after release. In-flight and buffered responses are discarded; stale mem_rdata ignored.

## Configuration
- MEM_SRAM_INIT_ALIGN_CHECK_EN defined: req_addr with low log2(WIDTH/8) bits non-zero is an error — no memory access, response with rsp_error = 1, rsp_rdata = 0, same latency/ordering as a normal request.
- Undefined: no check; all addresses passed through unchanged; rsp_error tied 0.

## Test plan
- Write 0x1122334455667788 to 0x008 strb 0xFF, then read 0x008 -> read rsp_valid cycle after accept, rsp_rdata = 0x1122334455667788, rsp_error = 0.
- Partial write strb 0x0F data 0xAAAAAAAABBBBBBBB over above, read 0x008 -> 0x11223344BBBBBBBB.
- Back-to-back reads 0x000..0x038, rsp_ready = 1 -> 8 responses on 8 consecutive cycles, req_ready never low.
- rsp_ready held low with req_valid = 1 -> exactly 2 accepts, req_ready = 0 after; release rsp_ready -> both responses in order, no loss.
- With MEM_SRAM_INIT_ALIGN_CHECK_EN: read 0x004 -> mem_cen = 0, rsp_error = 1, rsp_rdata = 0; without it: mem_cen = 1, mem_addr = 0x004, rsp_error = 0.
- Assert g_reset with 2 buffered responses -> rsp_valid = 0 immediately; after release first new read returns only its own data.
